// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared state, direction and screen constants for the crosshair renderer
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CENTRE = 2'd1,
        ARM    = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DIR_TOP    = 2'd0,
        DIR_RIGHT  = 2'd1,
        DIR_BOTTOM = 2'd2,
        DIR_LEFT   = 2'd3
    } dir_e;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    // step counter width, enough for arms of up to 15 pixels
    localparam int K_W          = 4;

endpackage

// File: rtl/crosshair_offset_clip.sv
// rtl/crosshair_offset_clip.sv - centre plus directional offset with off-screen detection
module crosshair_offset_clip
    import draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic [X_W-1:0] center_x,
    input  logic [Y_W-1:0] center_y,
    input  dir_e           dir,
    input  logic [K_W-1:0] k,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           on_screen
);

    logic [X_W:0] ext_x;
    logic [Y_W:0] ext_y;
    logic [X_W:0] k_x;
    logic [Y_W:0] k_y;

    assign k_x = (X_W+1)'(k);
    assign k_y = (Y_W+1)'(k);

    // k=0 yields the centre itself; a borrow wraps into the extra bit and fails the bound test
    always_comb begin
        ext_x = {1'b0, center_x};
        ext_y = {1'b0, center_y};
        case (dir)
            DIR_TOP:    ext_y = {1'b0, center_y} - k_y;
            DIR_RIGHT:  ext_x = {1'b0, center_x} + k_x;
            DIR_BOTTOM: ext_y = {1'b0, center_y} + k_y;
            DIR_LEFT:   ext_x = {1'b0, center_x} - k_x;
        endcase
    end

    assign pix_x     = ext_x[X_W-1:0];
    assign pix_y     = ext_y[Y_W-1:0];
    assign on_screen = (ext_x < (X_W+1)'(SCREEN_W)) && (ext_y < (Y_W+1)'(SCREEN_H));

endmodule

// File: rtl/draw_crosshair_multi.sv
// rtl/draw_crosshair_multi.sv - crosshair renderer FSM and VGA write port; CROSSHAIR_GAP_EN blanks pixels near the centre
module draw_crosshair_multi
    import draw_pkg::*;
#(
    parameter int ARM_LEN  = 1,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COLOUR_W = 18,
    parameter int GAP      = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      center_x,
    input  logic [Y_W-1:0]      center_y,
    input  logic [COLOUR_W-1:0] colour,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_write
);

    localparam logic [K_W-1:0] ARM_LEN_K = K_W'(ARM_LEN);
    localparam logic [K_W-1:0] GAP_K     = K_W'(GAP);
`ifdef CROSSHAIR_GAP_EN
    localparam logic GAP_ENABLED = 1'b1;
`else
    localparam logic GAP_ENABLED = 1'b0;
`endif

    state_e                state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [X_W-1:0]        cx_q, cx_d;
    logic [Y_W-1:0]        cy_q, cy_d;
    logic [X_W-1:0]        vga_x_q, vga_x_d;
    logic [Y_W-1:0]        vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
    logic                  vga_write_q, vga_write_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  pix_cycle;
    logic [X_W-1:0]        src_x;
    logic [Y_W-1:0]        src_y;
    logic [X_W-1:0]        pix_x;
    logic [Y_W-1:0]        pix_y;
    logic                  on_screen;
    logic                  gap_hit;

    // The next pixel is computed from (dir_d, k_d) so that it lands in the output registers
    // in the same cycle the FSM enters the matching state.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        k_d          = k_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        vga_colour_d = vga_colour_q;
        src_x        = cx_q;
        src_y        = cy_q;
        pix_cycle    = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = CENTRE;
                    cx_d         = center_x;
                    cy_d         = center_y;
                    vga_colour_d = colour;
                    src_x        = center_x;
                    src_y        = center_y;
                    dir_d        = DIR_TOP;
                    k_d          = '0;
                    pix_cycle    = 1'b1;
                end
            end
            CENTRE: begin
                state_d   = ARM;
                dir_d     = DIR_TOP;
                k_d       = K_W'(1);
                pix_cycle = 1'b1;
            end
            ARM: begin
                if (k_q == ARM_LEN_K) begin
                    if (dir_q == DIR_LEFT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        dir_d     = dir_e'(dir_q + 2'd1);
                        k_d       = K_W'(1);
                        pix_cycle = 1'b1;
                    end
                end else begin
                    k_d       = k_q + K_W'(1);
                    pix_cycle = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    crosshair_offset_clip #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .center_x  (src_x),
        .center_y  (src_y),
        .dir       (dir_d),
        .k         (k_d),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .on_screen (on_screen)
    );

    assign gap_hit = GAP_ENABLED && (k_d <= GAP_K);

    always_comb begin
        vga_x_d     = pix_cycle ? pix_x : vga_x_q;
        vga_y_d     = pix_cycle ? pix_y : vga_y_q;
        vga_write_d = pix_cycle && on_screen && !gap_hit;
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            dir_q        <= DIR_TOP;
            k_q          <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_write_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            k_q          <= k_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_write_q  <= vga_write_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_write  = vga_write_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_draw_crosshair_multi.sv
// tb/tb_draw_crosshair_multi.sv - scoreboard bench for draw_crosshair_multi against a pixel-list model
module tb_draw_crosshair_multi;

    localparam int L   = 2;
    localparam int GAP = 1;
`ifdef CROSSHAIR_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  center_x;
    logic [6:0]  center_y;
    logic [17:0] colour;
    logic        busy;
    logic        done;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;

    draw_crosshair_multi #(
        .ARM_LEN  (L),
        .X_W      (8),
        .Y_W      (7),
        .SCREEN_W (160),
        .SCREEN_H (120),
        .COLOUR_W (18),
        .GAP      (GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .center_x   (center_x),
        .center_y   (center_y),
        .colour     (colour),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_write  (vga_write)
    );

    typedef struct {
        int          cyc;
        int          x;
        int          y;
        logic [17:0] col;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [17:0] col;
    } col_t;

    wr_t         wq[$];
    col_t        colq[$];
    bit          busy_at[int];
    bit          done_at[int];
    logic [17:0] cur_col;
    int          cyc;
    int          checks;
    int          passes;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Reference: the crosshair as a list of (cycle, pixel) entries; cycle n after acceptance
    // is observed when cyc == e0 + n.
    task automatic model_accept(input int e0, input int x, input int y, input logic [17:0] c);
        int dxs[4];
        int dys[4];
        int n;
        int px;
        int py;
        dxs = '{0, 1, 0, -1};
        dys = '{-1, 0, 1, 0};
        n = 1;
        if (x < 160 && y < 120 && !(GAP_ON && 0 <= GAP))
            wq.push_back('{e0 + 1, x, y, c});
        for (int d = 0; d < 4; d++) begin
            for (int k = 1; k <= L; k++) begin
                n++;
                px = x + dxs[d] * k;
                py = y + dys[d] * k;
                if (px >= 0 && px < 160 && py >= 0 && py < 120 && !(GAP_ON && k <= GAP))
                    wq.push_back('{e0 + n, px, py, c});
            end
        end
        for (int i = 1; i <= 2 + 4 * L; i++) busy_at[e0 + i] = 1'b1;
        done_at[e0 + 2 + 4 * L] = 1'b1;
        colq.push_back('{e0 + 1, c});
    endtask

    task automatic model_reset();
        wq.delete();
        colq.delete();
        busy_at.delete();
        done_at.delete();
        cur_col = '0;
    endtask

    initial cur_col = '0;

    always @(negedge clock) begin
        while (colq.size() > 0 && colq[0].cyc <= cyc) begin
            cur_col = colq[0].col;
            void'(colq.pop_front());
        end
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            checks++;
            $display("FAIL missed_write @cyc %0d: got none expected (%0d,%0d)", wq[0].cyc, wq[0].x, wq[0].y);
            void'(wq.pop_front());
        end
        if (vga_write) begin
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                chk("wr_x", vga_x, wq[0].x);
                chk("wr_y", vga_y, wq[0].y);
                chk("wr_col", vga_colour, wq[0].col);
                void'(wq.pop_front());
            end else begin
                checks++;
                $display("FAIL unexpected_write @cyc %0d: got (%0d,%0d) expected no write", cyc, vga_x, vga_y);
            end
        end
        chk("busy", busy, busy_at.exists(cyc));
        chk("done", done, done_at.exists(cyc));
        chk("colour_hold", vga_colour, cur_col);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic run_seq(input int x, input int y, input logic [17:0] c);
        int e0;
        center_x = 8'(x);
        center_y = 7'(y);
        colour   = c;
        start    = 1'b1;
        e0       = cyc;
        model_accept(e0, x, y, c);
        step();
        start    = 1'b0;
        center_x = 8'($urandom);
        center_y = 7'($urandom);
        colour   = 18'($urandom);
        while (cyc < e0 + 3 + 4 * L) step();
    endtask

    initial begin
        int e0;
        checks   = 0;
        passes   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        center_x = '0;
        center_y = '0;
        colour   = '0;
        model_reset();
        repeat (3) step();
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_vga_colour", vga_colour, 0);
        chk("rst_vga_write", vga_write, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        run_seq(80, 60, 18'h3FFFF);
        run_seq(0, 0, 18'h00155);
        run_seq(159, 119, 18'h2A0F0);

        // start re-asserted mid-sequence must be ignored
        center_x = 8'd50;
        center_y = 7'd40;
        colour   = 18'h12345;
        start    = 1'b1;
        e0       = cyc;
        model_accept(e0, 50, 40, 18'h12345);
        step();
        start = 1'b0;
        while (cyc < e0 + 3) step();
        center_x = 8'd10;
        center_y = 7'd10;
        colour   = 18'h0AAAA;
        start    = 1'b1;
        step();
        start = 1'b0;
        while (cyc < e0 + 3 + 4 * L) step();

        // reset asserted during cycle 4 aborts without a done pulse
        center_x = 8'd70;
        center_y = 7'd30;
        colour   = 18'h3C3C3;
        start    = 1'b1;
        e0       = cyc;
        model_accept(e0, 70, 30, 18'h3C3C3);
        step();
        start = 1'b0;
        while (cyc < e0 + 4) step();
        reset = 1'b1;
        model_reset();
        step();
        chk("midrst_write", vga_write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        reset = 1'b0;
        step();
        run_seq(120, 5, 18'h01F01);

        // start held high: second sequence accepted in the idle cycle after DONE
        center_x = 8'd30;
        center_y = 7'd100;
        colour   = 18'h15A5A;
        start    = 1'b1;
        e0       = cyc;
        model_accept(e0, 30, 100, 18'h15A5A);
        model_accept(e0 + 3 + 4 * L, 30, 100, 18'h15A5A);
        while (cyc < e0 + 4 + 4 * L) step();
        start = 1'b0;
        while (cyc < e0 + 6 + 8 * L) step();

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) step();
            run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 18'($urandom));
        end

        repeat (4) step();
        chk("queue_drained", wq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/draw_crosshair_multi.md
Name: draw_crosshair_multi

Overview:
- Parametrised successor crosshair renderer; sits between the frame-render controller and the VGA adapter write port.
- On `start`, latches the centre pixel and colour, then emits one VGA write per cycle:
  - the centre pixel;
  - four arms of ARM_LEN pixels each, in order top, right, bottom, left.
- Pixels outside the screen are clipped: the cycle is consumed but no write is issued.
- `done` pulses once the sequence is complete.

Parameters:
- ARM_LEN, 1, pixels per arm (1..15).
- X_W, 8, vga_x / center_x width.
- Y_W, 7, vga_y / center_y width.
- SCREEN_W, 160, visible columns; x >= SCREEN_W is off-screen.
- SCREEN_H, 120, visible rows; y >= SCREEN_H is off-screen.
- COLOUR_W, 18, colour width.
- GAP, 1, arm pixels skipped next to the centre; used only with CROSSHAIR_GAP_EN.

Ports:
- clock  in  1  global clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- center_x  in  X_W  centre column, in pixels.
- center_y  in  Y_W  centre row, in pixels.
- colour  in  COLOUR_W  crosshair colour; latched with the centre.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- vga_x  out  X_W  registered pixel column.
- vga_y  out  Y_W  registered pixel row.
- vga_colour  out  COLOUR_W  registered latched colour.
- vga_write  out  1  registered write strobe.

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: vga_x=0, vga_y=0, vga_colour=0, vga_write=0, done=0, busy=0; state=IDLE.
- States: IDLE -> CENTRE -> ARM -> DONE -> IDLE.
  - ARM holds a 2-bit direction (0 top, 1 right, 2 bottom, 3 left) and a step counter k = 1..ARM_LEN.
- Accept: in IDLE with start=1 at edge E0:
  - latch center_x, center_y, colour;
  - go to CENTRE.
- Start outside IDLE is ignored, with no queueing.
- Pixel cycles:
  - The CENTRE pixel appears on the outputs in the cycle after E0.
  - Each following cycle presents the next pixel: k increments, and on k=ARM_LEN the direction advances and k resets to 1.
  - After left, k=ARM_LEN, go to DONE.
- Latency is fixed and independent of clipping:
  - pixel cycles = 1 + 4*ARM_LEN;
  - done=1 in cycle 2 + 4*ARM_LEN after E0, for exactly one cycle;
  - IDLE follows DONE.
- Coordinate arithmetic:
  - computed at X_W+1 / Y_W+1 bits as centre ± k;
  - a borrow (negative) result, x >= SCREEN_W, or y >= SCREEN_H means off-screen.
  - Off-screen pixel: vga_write=0 in that cycle. vga_x/vga_y still present the truncated value, which is don't-care.
  - An off-screen centre suppresses the centre write only; the arms are still evaluated individually.
- vga_write=0 in IDLE and DONE.
- vga_colour holds the latched colour from CENTRE through DONE. It retains that value in IDLE until the next accept.
- Reset mid-sequence: at the next edge, return to IDLE with all outputs at their reset values; no done pulse.
- start held high: a new sequence is accepted in the first IDLE cycle after DONE, i.e. back-to-back with one idle cycle.

Optional Feature:
- CROSSHAIR_GAP_EN defined:
  - centre pixel and arm pixels k <= GAP have vga_write forced to 0;
  - cycle count is unchanged, so latency is identical.
- Undefined: GAP is ignored; all on-screen pixels are written.

Decomposition:
- Package draw_pkg: state encodings (IDLE, CENTRE, ARM, DONE), direction codes DIR_TOP/RIGHT/BOTTOM/LEFT, default SCREEN_W/SCREEN_H.
- Sub-module crosshair_offset_clip (combinational):
  - inputs: latched centre, direction, k;
  - outputs: pixel x/y and an on_screen flag.
- The top level holds the FSM, counters and output registers.

Test Plan:
- Nominal: ARM_LEN=2, centre (80,60), colour 18'h3FFFF.
  - Writes in order: (80,60),(80,59),(80,58),(81,60),(82,60),(80,61),(80,62),(79,60),(78,60).
  - done in cycle 10 after E0; busy high for cycles 1..10.
- Corner clip: ARM_LEN=2, centre (0,0).
  - Only (0,0),(1,0),(2,0),(0,1),(0,2) written.
  - Top and left cycles have vga_write=0; done still in cycle 10.
- Far-edge clip: ARM_LEN=1, centre (159,119).
  - Writes (159,119),(159,118),(158,119); right and bottom suppressed.
  - done in cycle 6.
- Start while busy: pulse start again in cycle 3 with centre (10,10).
  - Ignored: pixel sequence unchanged, single done pulse.
- Reset mid-op: assert reset in cycle 4.
  - Next cycle: vga_write=0, busy=0, done=0.
  - No done pulse; a subsequent start runs a full sequence.
- CROSSHAIR_GAP_EN, GAP=1, ARM_LEN=3, centre (80,60):
  - 13 pixel cycles, only k=2,3 written (8 writes);
  - centre not written; done in cycle 14.
